// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter:
//   - RV32I load/store funct3 encodings
//   - FSM state encoding (IDLE / RESP)
//   - memory word-index width
//   - access_legal(): alignment / funct3 legality of a request
// -----------------------------------------------------------------------------
package dmem_pkg;

  // Memory is word addressed: byte address bits [23:2].
  localparam int MEM_AW = 22;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings (share the low three codes with the loads).
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // FSM state encoding.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;  // no response pending
  localparam state_t ST_RESP = 1'b1;  // rsp_valid high

  // A request is legal when its funct3 exists for its direction and the
  // byte offset is naturally aligned for the access size.
  function automatic logic access_legal(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_LB:   ok = 1'b1;                 // LB / SB
      F3_LH:   ok = ~off[0];              // LH / SH
      F3_LW:   ok = (off == 2'b00);       // LW / SW
      F3_LBU:  ok = ~we;
      F3_LHU:  ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// -----------------------------------------------------------------------------
// dmem_load_align
// Combinational load formatter: selects the addressed byte/halfword of a
// memory word and sign- or zero-extends it according to funct3.
// Ports:
//   funct3 [2:0]  load funct3 (LB, LH, LW, LBU, LHU; anything else -> 0)
//   offset [1:0]  byte offset within the word
//   word   [31:0] raw memory read data
//   data   [31:0] formatted load result
// -----------------------------------------------------------------------------
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    byte_sel = word[7:0];
    case (offset)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    data = '0;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data = word;
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester (0 = core LSU, 1 = DMA) round-robin arbiter in front of a
// single-port word memory with one-cycle read latency. Performs RV32I store
// lane steering, load extraction and alignment checking, and returns one
// response per accepted request in the following cycle.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   req_valid/req_ready[1:0] per-requester handshake
//   req_we, req_funct3, req_addr, req_wdata   per-requester request fields
//   rsp_valid/rsp_ready      response handshake (held until accepted)
//   rsp_id, rsp_rdata, rsp_err               response owner, data, error
//   mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata   memory request port
//   mem_rdata                read data, one cycle after a read strobe
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_we,
  input  logic [1:0][2:0]  req_funct3,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [21:0]      mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  state_t      state_q;
  logic        last_q;     // requester granted at the last acceptance
  logic        id_q;
  logic        err_q;
  logic        load_q;
  logic        first_q;    // first cycle of the current response
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] hold_q;     // load data captured for stalled response cycles

  logic        gnt;
  logic        can_accept;
  logic        accept;
  logic        legal;
  logic        issue;
  logic        sel_we;
  logic [2:0]  sel_f3;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] align_data;
  logic [31:0] fmt_data;
  logic        unused_addr_hi;

  // Round-robin: on contention favour the requester not granted last. With
  // no one valid, the ready is offered to the favoured requester so that
  // req_ready never follows a requester's own valid beyond arbitration.
  always_comb begin
    gnt = ~last_q;
    if (req_valid == 2'b11) gnt = ~last_q;
    else if (req_valid[1])  gnt = 1'b1;
    else if (req_valid[0])  gnt = 1'b0;
  end

  assign can_accept = ~RST & ((state_q == ST_IDLE) | rsp_ready);
  assign req_ready  = can_accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign accept     = can_accept & req_valid[gnt];

  assign sel_we    = req_we[gnt];
  assign sel_f3    = req_funct3[gnt];
  assign sel_addr  = req_addr[gnt];
  assign sel_wdata = req_wdata[gnt];

  assign legal = access_legal(sel_we, sel_f3, sel_addr[1:0]);
  assign issue = accept & legal;

  // Only byte-address bits [23:0] reach the memory.
  assign unused_addr_hi = ^sel_addr[31:24];

  always_comb begin
    mem_en    = issue;
    mem_we    = issue & sel_we;
    mem_addr  = issue ? sel_addr[MEM_AW+1:2] : '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (issue && sel_we) begin
      case (sel_f3)
        F3_SB: begin
          mem_wstrb = 4'b0001 << sel_addr[1:0];
          mem_wdata = {4{sel_wdata[7:0]}};
        end
        F3_SH: begin
          mem_wstrb = sel_addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{sel_wdata[15:0]}};
        end
        default: begin
          mem_wstrb = 4'b1111;
          mem_wdata = sel_wdata;
        end
      endcase
    end
  end

  dmem_load_align u_load_align (
    .funct3 (f3_q),
    .offset (off_q),
    .word   (mem_rdata),
    .data   (align_data)
  );

  // Stores and errors return zero data.
  assign fmt_data  = (load_q & ~err_q) ? align_data : '0;

  assign rsp_valid = (state_q == ST_RESP) & ~RST;
  assign rsp_id    = rsp_valid & id_q;
  assign rsp_err   = rsp_valid & err_q;
  // mem_rdata is only valid in the first response cycle; later stalled
  // cycles replay the captured copy.
  assign rsp_rdata = !rsp_valid ? '0 : (first_q ? fmt_data : hold_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;      // favour requester 0 on the next contest
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      first_q <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      hold_q  <= '0;
    end else begin
      if (state_q == ST_RESP && first_q) hold_q <= fmt_data;
      if (accept) begin
        state_q <= ST_RESP;
        first_q <= 1'b1;
        last_q  <= gnt;
        id_q    <= gnt;
        err_q   <= ~legal;
        load_q  <= ~sel_we;
        f3_q    <= sel_f3;
        off_q   <= sel_addr[1:0];
      end else begin
        first_q <= 1'b0;
        if (state_q == ST_RESP && rsp_ready) state_q <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench: directed scenarios followed by randomized traffic,
// all compared every cycle against a transaction-level model (pending
// response, last grant, shadow memory) and a separate memory responder.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic             CLK = 1'b0;
  logic             RST;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][2:0]  req_funct3;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             mem_en;
  logic             mem_we;
  logic [21:0]      mem_addr;
  logic [3:0]       mem_wstrb;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  dmem_arbiter dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  // Memory as seen through the DUT's write port, and as the spec says it
  // should look.
  logic [31:0] phys   [16];
  logic [31:0] shadow [16];

  // Transaction-level model state.
  int          last_gnt;
  bit          pend;
  int          p_id;
  bit          p_err;
  logic [31:0] p_data;

  // Outputs sampled mid-cycle.
  logic [1:0]  s_ready;
  logic        s_mem_en, s_mem_we, s_rsp_valid, s_rsp_id, s_rsp_err;
  logic [21:0] s_mem_addr;
  logic [3:0]  s_wstrb;
  logic [31:0] s_wdata, s_rdata;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit legal_req(bit we, int f3, int addr);
    int off = addr % 4;
    if (we) return f3 == 0 || (f3 == 1 && off % 2 == 0) || (f3 == 2 && off == 0);
    return f3 == 0 || f3 == 4 || ((f3 == 1 || f3 == 5) && off % 2 == 0) ||
           (f3 == 2 && off == 0);
  endfunction

  function automatic logic [31:0] load_value(int f3, int addr, logic [31:0] word);
    int off = addr % 4;
    logic [31:0] b = (word >> (8 * off)) & 32'hFF;
    logic [31:0] h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      0:       return (b >= 128)   ? b - 32'd256   : b;
      1:       return (h >= 32768) ? h - 32'd65536 : h;
      2:       return word;
      4:       return b;
      5:       return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(logic [31:0] old, int f3, int addr,
                                              logic [31:0] data);
    int off = addr % 4;
    logic [31:0] mask;
    case (f3)
      0: begin
        mask = 32'hFF << (8 * off);
        return (old & ~mask) | ((data & 32'hFF) << (8 * off));
      end
      1: begin
        mask = 32'hFFFF << (16 * (off / 2));
        return (old & ~mask) | ((data & 32'hFFFF) << (16 * (off / 2)));
      end
      default: return data;
    endcase
  endfunction

  task automatic set_req(int r, bit we, int f3, int addr, logic [31:0] data);
    req_we[r]     = we;
    req_funct3[r] = 3'(f3);
    req_addr[r]   = 32'(addr);
    req_wdata[r]  = data;
  endtask

  // One clock cycle: inputs are already applied (posedge+1); check at
  // posedge+4, then advance model and memory across the edge.
  task automatic tick();
    int g, a, w, f3;
    bit can, acc, lg, we;
    logic [31:0] d;
    #3;
    s_ready     = req_ready;
    s_mem_en    = mem_en;
    s_mem_we    = mem_we;
    s_mem_addr  = mem_addr;
    s_wstrb     = mem_wstrb;
    s_wdata     = mem_wdata;
    s_rsp_valid = rsp_valid;
    s_rsp_id    = rsp_id;
    s_rsp_err   = rsp_err;
    s_rdata     = rsp_rdata;

    if (req_valid == 2'b11)  g = (last_gnt == 0) ? 1 : 0;
    else if (req_valid[1])   g = 1;
    else if (req_valid[0])   g = 0;
    else                     g = (last_gnt == 0) ? 1 : 0;
    a  = int'(req_addr[g]);
    w  = (a / 4) % 16;
    f3 = int'(req_funct3[g]);
    we = req_we[g];
    d  = req_wdata[g];
    lg = legal_req(we, f3, a);
    can = !RST && (!pend || rsp_ready);
    acc = can && req_valid[g];

    if (RST) begin
      check("rst_req_ready", s_ready, 0);
      check("rst_rsp_valid", s_rsp_valid, 0);
      check("rst_rsp_id", s_rsp_id, 0);
      check("rst_rsp_err", s_rsp_err, 0);
      check("rst_rsp_rdata", s_rdata, 0);
      check("rst_mem_en", s_mem_en, 0);
    end else begin
      check("req_ready", s_ready, can ? (g == 1 ? 2 : 1) : 0);
      check("mem_en", s_mem_en, acc && lg);
      if (acc && lg) begin
        check("mem_we", s_mem_we, we);
        check("mem_addr", s_mem_addr, (a / 4) % (1 << 22));
        if (we) begin
          check("mem_wstrb", s_wstrb,
                f3 == 0 ? (1 << (a % 4)) : f3 == 1 ? ((a % 4) >= 2 ? 12 : 3) : 15);
          check("mem_wdata", s_wdata,
                f3 == 0 ? (d & 32'hFF) * 32'h01010101 :
                f3 == 1 ? (d & 32'hFFFF) * 32'h00010001 : d);
        end else begin
          check("mem_wstrb_rd", s_wstrb, 0);
        end
      end else begin
        check("idle_mem_we", s_mem_we, 0);
        check("idle_wstrb", s_wstrb, 0);
      end
      check("rsp_valid", s_rsp_valid, pend);
      if (pend) begin
        check("rsp_id", s_rsp_id, p_id);
        check("rsp_err", s_rsp_err, p_err);
        check("rsp_rdata", s_rdata, p_data);
      end
    end

    @(posedge CLK);
    if (s_mem_en && s_mem_we)
      for (int l = 0; l < 4; l++)
        if (s_wstrb[l]) phys[s_mem_addr[3:0]][8*l +: 8] = s_wdata[8*l +: 8];

    if (RST) begin
      pend     = 0;
      last_gnt = 1;
    end else begin
      if (pend && rsp_ready) pend = 0;
      if (acc) begin
        pend     = 1;
        p_id     = g;
        p_err    = !lg;
        p_data   = (lg && !we) ? load_value(f3, a, shadow[w]) : 32'd0;
        if (lg && we) shadow[w] = store_merge(shadow[w], f3, a, d);
        last_gnt = g;
      end
    end
    #1;
    mem_rdata = (s_mem_en && !s_mem_we) ? phys[s_mem_addr[3:0]] : $urandom;
  endtask

  initial begin
    RST        = 1'b1;
    req_valid  = 2'b11;
    req_we     = '0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;
    mem_rdata  = '0;
    for (int i = 0; i < 16; i++) begin
      phys[i]   = $urandom;
      shadow[i] = phys[i];
    end
    phys[4] = 32'h0000_8000;  shadow[4] = 32'h0000_8000;
    phys[0] = 32'hABCD_0000;  shadow[0] = 32'hABCD_0000;
    pend     = 0;
    last_gnt = 1;

    @(posedge CLK);
    #1;
    tick();
    tick();
    check("reset_ready_lit", s_ready, 2'b00);
    check("reset_valid_lit", s_rsp_valid, 1'b0);
    RST = 1'b0;

    // Requester 1 LB / LBU at 0x11 with word 0x00008000.
    req_valid = 2'b10;
    set_req(1, 0, 0, 'h11, 0);
    tick();
    check("lb_mem_addr_lit", s_mem_addr, 4);
    req_valid = 2'b00;
    tick();
    check("lb_rdata_lit", s_rdata, 32'hFFFF_FF80);
    check("lb_id_lit", s_rsp_id, 1);
    req_valid = 2'b10;
    set_req(1, 0, 4, 'h11, 0);
    tick();
    req_valid = 2'b00;
    tick();
    check("lbu_rdata_lit", s_rdata, 32'h0000_0080);

    // Requester 0 SW 0xDEADBEEF at 0x10.
    req_valid = 2'b01;
    set_req(0, 1, 2, 'h10, 32'hDEAD_BEEF);
    tick();
    check("sw_mem_addr_lit", s_mem_addr, 4);
    check("sw_wstrb_lit", s_wstrb, 4'b1111);
    check("sw_we_lit", s_mem_we, 1);
    req_valid = 2'b00;
    tick();
    check("sw_rsp_valid_lit", s_rsp_valid, 1);
    check("sw_rsp_id_lit", s_rsp_id, 0);
    check("sw_rsp_err_lit", s_rsp_err, 0);

    // Misaligned LW at 0x6.
    req_valid = 2'b01;
    set_req(0, 0, 2, 'h6, 0);
    tick();
    check("lw_mis_mem_en_lit", s_mem_en, 0);
    req_valid = 2'b00;
    tick();
    check("lw_mis_err_lit", s_rsp_err, 1);
    check("lw_mis_rdata_lit", s_rdata, 0);

    // LH at 0x2 then three stalled response cycles.
    req_valid = 2'b01;
    set_req(0, 0, 1, 'h2, 0);
    tick();
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    set_req(1, 0, 2, 'h20, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_rdata_lit", s_rdata, 32'hFFFF_ABCD);
      check("stall_ready_lit", s_ready, 0);
      check("stall_mem_en_lit", s_mem_en, 0);
    end
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    tick();

    // Contention with rsp_ready=1: grants alternate, one response per cycle.
    req_valid = 2'b11;
    set_req(0, 0, 2, 'h0, 0);
    set_req(1, 0, 2, 'h20, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_grant_lit", s_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0) check("rr_rsp_valid_lit", s_rsp_valid, 1);
    end

    // Reset pulse while a response is pending.
    RST = 1'b1;
    tick();
    check("rst_resp_mem_en_lit", s_mem_en, 0);
    RST = 1'b0;
    tick();
    check("post_rst_valid_lit", s_rsp_valid, 0);
    check("post_rst_grant_lit", s_ready, 2'b01);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      RST       = ($urandom_range(0, 99) == 0);
      req_valid = 2'($urandom);
      for (int r = 0; r < 2; r++)
        set_req(r, bit'($urandom % 2), int'($urandom % 8), int'($urandom % 64), $urandom);
      rsp_ready = ($urandom % 4) != 0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
